// File: rtl/hwpe_stream_fence_serializer_pkg.sv
// Shared types and helpers for the fence serializer: FSM state encoding and
// the beat-index width calculation.
package hwpe_stream_fence_serializer_pkg;

  typedef enum logic {FSER_EMPTY, FSER_SER} fence_ser_state_t;

  // Index width never drops below one bit, so NB_STREAMS = 1 still has a port.
  function automatic int unsigned fser_idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hwpe_stream_fence_serializer_if.sv
// Valid/ready stream with byte strobes. The source drives valid/data/strb and
// the sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_fence_serializer.sv
// Captures one aligned group of NB_STREAMS words and replays it as
// NB_STREAMS consecutive beats on a single output stream, index order.
module hwpe_stream_fence_serializer
  import hwpe_stream_fence_serializer_pkg::*;
#(
  parameter int unsigned NB_STREAMS = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      clear_i,
  input  logic                                      test_mode_i,
  hwpe_stream_intf_stream.sink                      push_i [NB_STREAMS-1:0],
  hwpe_stream_intf_stream.source                    pop_o,
  output logic                                      last_o,
  output logic [fser_idx_width(NB_STREAMS)-1:0]     beat_idx_o,
  output logic                                      busy_o
);

  localparam int unsigned     IDXW     = fser_idx_width(NB_STREAMS);
  localparam int unsigned     STRBW    = DATA_WIDTH / 8;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB_STREAMS - 1);

  fence_ser_state_t  state_q, state_d;
  logic [IDXW-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] grp_data_q [NB_STREAMS];
  logic [DATA_WIDTH-1:0] grp_data_d [NB_STREAMS];
  logic [STRBW-1:0]      grp_strb_q [NB_STREAMS];
  logic [STRBW-1:0]      grp_strb_d [NB_STREAMS];

  logic [NB_STREAMS-1:0] valid_vec;
  logic [DATA_WIDTH-1:0] data_in [NB_STREAMS];
  logic [STRBW-1:0]      strb_in [NB_STREAMS];

  logic all_valid, hs_out, last_hs, can_load, load, push_ready;
  logic unused_test_mode;

  assign unused_test_mode = test_mode_i;

  for (genvar i = 0; i < NB_STREAMS; i++) begin : g_push
    assign valid_vec[i]    = push_i[i].valid;
    assign data_in[i]      = push_i[i].data;
    assign strb_in[i]      = push_i[i].strb;
    assign push_i[i].ready = push_ready;
  end

  assign all_valid  = &valid_vec;
  assign hs_out     = pop_o.valid & pop_o.ready;
  assign last_hs    = hs_out & (cnt_q == LAST_IDX);
  assign can_load   = (state_q == FSER_EMPTY) | last_hs;
  assign load       = all_valid & can_load;
  // Ready is masked during reset so no group is offered to a resetting block.
  assign push_ready = load & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FSER_EMPTY;
      cnt_q   <= '0;
      for (int i = 0; i < NB_STREAMS; i++) begin
        grp_data_q[i] <= '0;
        grp_strb_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grp_data_q <= grp_data_d;
      grp_strb_q <= grp_strb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grp_data_d = grp_data_q;
    grp_strb_d = grp_strb_q;
    if (clear_i) begin
      state_d = FSER_EMPTY;
      cnt_d   = '0;
      for (int i = 0; i < NB_STREAMS; i++) begin
        grp_data_d[i] = '0;
        grp_strb_d[i] = '0;
      end
    end else if (load) begin
      // Covers both the idle load and the zero-bubble reload on the last beat.
      state_d    = FSER_SER;
      cnt_d      = '0;
      grp_data_d = data_in;
      grp_strb_d = strb_in;
    end else if (hs_out) begin
      if (cnt_q == LAST_IDX) begin
        state_d = FSER_EMPTY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    pop_o.valid = (state_q == FSER_SER);
    pop_o.data  = grp_data_q[cnt_q];
    pop_o.strb  = grp_strb_q[cnt_q];
    beat_idx_o  = cnt_q;
    last_o      = (state_q == FSER_SER) & (cnt_q == LAST_IDX);
    busy_o      = (state_q == FSER_SER);
  end

endmodule
